// File: rtl/arbiter.sv
// Round-robin, non-preemptive arbiter: registered one-hot grant, 1-cycle grant/handover latency.
// The owner keeps the grant while it holds its request; there is no backpressure path beyond r itself.
module arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] r,
  output logic [N-1:0] g
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [N-1:0]  g_q, g_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          hold;
  logic          found;

  assign hold = |(g_q & r);

  always_comb begin
    g_d   = g_q;
    ptr_d = ptr_q;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    if (!hold) begin
      g_d = '0;
      // Scan ptr, ptr+1, ... modulo N so non-power-of-two N wraps cleanly.
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr_q} + (PW+1)'(k);
        if (sum >= N_W) sum = sum - N_W;
        idx = sum[PW-1:0];
        if (!found && r[idx]) begin
          found    = 1'b1;
          g_d[idx] = 1'b1;
          ptr_d    = (sum == N_W - (PW+1)'(1)) ? '0 : idx + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      g_q   <= '0;
      ptr_q <= '0;
    end else begin
      g_q   <= g_d;
      ptr_q <= ptr_d;
    end
  end

  assign g = g_q;

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for the 3-requester round-robin arbiter with a per-cycle one-hot monitor.
module tb_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] r;
  logic [2:0] g;
  int         n_chk  = 0;
  int         n_fail = 0;
  logic       running = 1'b0;

  arbiter #(.N(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .r      (r),
    .g      (g)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (running) begin
      n_chk++;
      assert ($onehot0(g)) else begin
        n_fail++;
        $error("FAIL onehot: g=%b required zero or one bit set", g);
      end
    end
  end

  task automatic tick(input logic [2:0] rv, input logic rst);
    @(negedge clk);
    r      = rv;
    resetn = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    n_chk++;
    assert (g === exp) else begin
      n_fail++;
      $error("FAIL %s: g=%b required %b", tag, g, exp);
    end
  endtask

  initial begin
    r      = 3'b000;
    resetn = 1'b1;
    running = 1'b1;

    // Reset held with all requests pending
    for (int i = 0; i < 10; i++) begin
      tick(3'b111, 1'b1); chk("reset_hold", 3'b000);
    end
    tick(3'b111, 1'b0); chk("reset_release", 3'b001);

    // Single requester and gapless handover
    tick(3'b000, 1'b1); chk("reset2", 3'b000);
    tick(3'b001, 1'b0); chk("single_req0", 3'b001);
    tick(3'b010, 1'b0); chk("handover_0_to_1", 3'b010);

    // Hold, no preemption
    tick(3'b011, 1'b0); chk("no_preempt", 3'b010);
    tick(3'b001, 1'b0); chk("release_to_0", 3'b001);

    // Round-robin fairness with all requesting
    tick(3'b111, 1'b1); chk("reset3", 3'b000);
    tick(3'b111, 1'b0); chk("rr_first", 3'b001);
    tick(3'b111, 1'b0); chk("rr_hold_a", 3'b001);
    tick(3'b111, 1'b0); chk("rr_hold_b", 3'b001);
    tick(3'b110, 1'b0); chk("rr_to_1", 3'b010);
    tick(3'b111, 1'b0); chk("rr_keep_1", 3'b010);
    tick(3'b101, 1'b0); chk("rr_to_2", 3'b100);
    tick(3'b111, 1'b0); chk("rr_keep_2", 3'b100);
    tick(3'b011, 1'b0); chk("rr_wrap_0", 3'b001);
    tick(3'b111, 1'b0); chk("rr_keep_0", 3'b001);

    // Pointer wrap and idle
    tick(3'b100, 1'b0); chk("grant_2", 3'b100);
    tick(3'b000, 1'b0); chk("idle", 3'b000);
    tick(3'b101, 1'b0); chk("ptr_wrapped", 3'b001);

    // Mid-operation reset clears grant and pointer
    tick(3'b010, 1'b0); chk("own_1", 3'b010);
    tick(3'b010, 1'b1); chk("mid_reset", 3'b000);
    tick(3'b110, 1'b0); chk("after_mid_reset", 3'b010);
    tick(3'b100, 1'b0); chk("no_grant_unrequested", 3'b100);
    tick(3'b000, 1'b0); chk("final_idle", 3'b000);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter.md
Name: arbiter

Overview:
- Round-robin, non-preemptive arbiter for N requesters (default 3) sharing one resource.
- Registered, one-hot grant output with at most one bit set.
- The current owner keeps the grant for as long as it holds its request.
- On release, the grant moves to the next requester in rotating order, so no requester starves.

Parameters:
- N, 3, number of requesters (≥2); sets the width of r and g.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- resetn  input  1  synchronous, active-high reset. Sampled on the rising edge of clk; a value of 1 resets the block. The port keeps the codebase name resetn, but its polarity is high.
- r  input  N  request vector; r[i]=1 means requester i wants the resource. Level-sensitive, sampled each rising edge.
- g  output  N  grant vector; one-hot or zero; g[i]=1 means requester i owns the resource. Driven directly from a register.

Behaviour:
- State:
  - grant register g[N-1:0].
  - priority pointer ptr (clog2(N) bits), holding the index that has highest priority at the next arbitration.
- Reset (resetn=1 at rising edge):
  - g=0, ptr=0.
  - Reset wins over every other condition, including reset mid-grant.
  - The grant drops in the cycle after the reset edge, with no partial grant.
- Each rising edge with resetn=0, in priority order:
  1. Hold: if g[k]=1 and r[k]=1, keep g unchanged and keep ptr unchanged.
  2. Arbitrate: otherwise (g=0, or the owner k has dropped r[k]), scan indices ptr, ptr+1, …, ptr+N-1 (mod N).
     - Grant the first index j with r[j]=1: g becomes one-hot j, ptr becomes (j+1) mod N.
  3. Idle: if no request is present, g=0 and ptr is unchanged.
- Latency:
  - A request is granted one cycle after it is first sampled, when the resource is free.
  - Handover after the owner drops its request also takes exactly one edge, with no idle cycle between owners. A new owner is visible in the same cycle the old grant clears.
- No preemption: a higher-priority request never revokes an active grant.
- One-hot invariant: g is either all zeros or has exactly one bit set, in every cycle.
- Simultaneous requests: the pointer order decides. Example after reset, with r=111: grant 0, then 1, then 2, then 0 again, as each owner releases.
- A grant is never issued to a requester whose r bit is 0 at the sampling edge.
- ptr is wrap-safe for non-power-of-two N: the modulo-N increment wraps 2→0 for N=3.
- Inputs may change asynchronously to the clock edge; only values sampled at the edge matter.
- Implementation: a case statement over the rotating scan, or a state machine with states IDLE and OWN_0..OWN_{N-1}, with ptr derived from the last owner.

Test Plan:
- Reset: resetn=1 for 10 cycles with r=111 → g=000 throughout. Release resetn → g=001 on the first edge after release.
- Single requester: r=001 → g=001 after one edge. Switch r to 010 → next edge g=010 (owner 0 released, requester 1 granted with no gap).
- Hold, no preemption: owner 1 holds (g=010) and r changes to 011 → g stays 010. Then r=001 → g=001 on the next edge.
- Round-robin fairness: from reset with r=111 held for 3 cycles, then the owner's bit pulsed low one cycle at a time → grant sequence 001→010→100→001. g is never 0 while any requested bit is high after the first grant.
- Pointer wrap and idle: grant 100, then r=000 → g=000. Then r=101 → g=001 (ptr wrapped to 0 after owner 2).
- Mid-operation reset: while g=010 with r=010, assert resetn=1 for one edge → g=000, ptr=0. Deassert with r=110 → g=010 (lowest index ≥ptr=0 that is requesting). Check the one-hot assertion on g every cycle of every test.
